// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between writeback and buffered MDU results.
// Latency: writeback grant -> rf_we next cycle; MDU push -> eligible next cycle -> rf_we one cycle later.
// Backpressure: mdu_ready drops when the FIFO is full; a starved head raises a one-cycle stall_pipe.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  query_rs,
  input  logic [4:0]  query_rt,
  output logic        pend_hit,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifoRd   [DEPTH];
  logic [31:0]   fifoData [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [GW-1:0] age;

  logic fifoEmpty;
  logic fifoFull;
  logic push;
  logic pop;
  logic wbGrant;
  logic starveNext;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == CW'(DEPTH));
  assign mdu_ready = !fifoFull;

  // A zero destination completes the handshake but is never stored.
  assign push = mdu_valid && !fifoFull && (mdu_rd != 5'd0);

  // A stall cycle belongs to the FIFO; the stalled pipeline re-presents its write.
  assign wbGrant = !stall_pipe && regwriteW && (rdW != 5'd0);
  assign pop     = !fifoEmpty && (stall_pipe || !(regwriteW && (rdW != 5'd0)));

  assign starveNext = !stall_pipe && !fifoEmpty && !pop &&
                      (age == GW'(STARVE_LIMIT - 1));

  logic [AW-1:0] slot;
  always_comb begin
    pend_hit = 1'b0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Entry i is live when its distance from the read pointer is below the fill count.
      slot = AW'(i) - rdPtr;
      if (CW'(slot) < count) begin
        if ((query_rs != 5'd0) && (fifoRd[i] == query_rs)) pend_hit = 1'b1;
        if ((query_rt != 5'd0) && (fifoRd[i] == query_rt)) pend_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoRd[wrPtr]   <= mdu_rd;
      fifoData[wrPtr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      age        <= '0;
      stall_pipe <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      if (fifoEmpty || pop)
        age <= '0;
      else if (age != GW'(STARVE_LIMIT))
        age <= age + 1'b1;

      stall_pipe <= starveNext;

      rf_we <= pop || wbGrant;
      if (pop) begin
        rf_waddr <= fifoRd[rdPtr];
        rf_wdata <= fifoData[rdPtr];
      end else if (wbGrant) begin
        rf_waddr <= rdW;
        rf_wdata <= resultW;
      end else begin
        rf_waddr <= 5'd0;
        rf_wdata <= 32'd0;
      end
    end
  end

endmodule
